// File: rtl/mismatch_scoreboard.sv
// -----------------------------------------------------------------------------
// mismatch_scoreboard
//
// Purpose:
//   Hardware scoreboard that compares a reference output vector with a DUT
//   output vector on every clock edge where 'sample' is high. The vectors are
//   split into NCH independent channels of CH_W bits each. The block keeps
//   saturating counters (samples, failing samples, per-channel failures),
//   captures the index and channel mask of the first failing sample, and
//   reports an overall EMPTY / PASS / FAIL status.
//
// Optional feature (compile-time macro CARE_MASK_EN):
//   When defined, an extra input 'care_mask' is added. Bits with care_mask=0
//   are excluded from the comparison (don't-care reference bits). When the
//   macro is undefined the port does not exist and every bit is compared.
//
// Ports:
//   clk            in   1          sampling clock
//   resetn         in   1          asynchronous active-low reset
//   clear          in   1          synchronous clear of all state (beats sample)
//   sample         in   1          compare ref_vec/dut_vec this cycle
//   care_mask      in   NCH*CH_W   (CARE_MASK_EN only) 1 = compare this bit
//   ref_vec        in   NCH*CH_W   reference outputs, channel k = [k*CH_W +: CH_W]
//   dut_vec        in   NCH*CH_W   DUT outputs, same packing
//   mismatch       out  1          last sample had any channel mismatch
//   mismatch_ch    out  NCH        per-channel mismatch of last sample
//   sample_cnt     out  CNT_W      samples taken, saturating
//   err_cnt        out  CNT_W      failing samples, saturating
//   ch_err_cnt     out  NCH*CNT_W  per-channel failure counts, saturating
//   first_err_idx  out  CNT_W      sample index of first failing sample
//   first_err_ch   out  NCH        mismatch mask of first failing sample
//   status         out  2          00 EMPTY, 01 PASS, 10 FAIL
// -----------------------------------------------------------------------------
module mismatch_scoreboard #(
  parameter int NCH   = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 sample,
`ifdef CARE_MASK_EN
  input  logic [NCH*CH_W-1:0]  care_mask,
`endif
  input  logic [NCH*CH_W-1:0]  ref_vec,
  input  logic [NCH*CH_W-1:0]  dut_vec,
  output logic                 mismatch,
  output logic [NCH-1:0]       mismatch_ch,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [NCH*CNT_W-1:0] ch_err_cnt,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [NCH-1:0]       first_err_ch,
  output logic [1:0]           status
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_PASS  = 2'b01,
    ST_FAIL  = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic                 mismatch_q, mismatch_d;
  logic [NCH-1:0]       mismatch_ch_q, mismatch_ch_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [NCH*CNT_W-1:0] ch_err_cnt_q, ch_err_cnt_d;
  logic [CNT_W-1:0]     first_err_idx_q, first_err_idx_d;
  logic [NCH-1:0]       first_err_ch_q, first_err_ch_d;

  logic [NCH*CH_W-1:0]  diff;
  logic [NCH-1:0]       cmp_ch;
  logic                 cmp_any;

  // Counters hold at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Bitwise compare of the two vectors, optionally masked, then OR-reduced
  // per channel so each channel flags if any of its bits differ.
  always_comb begin
    diff = ref_vec ^ dut_vec;
`ifdef CARE_MASK_EN
    diff = diff & care_mask;
`endif
    cmp_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      cmp_ch[k] = |diff[k*CH_W +: CH_W];
    end
    cmp_any = |cmp_ch;
  end

  // Datapath next-state: clear wipes everything and discards the sample;
  // otherwise a sample bumps the counters and reloads the mismatch flags.
  // A first failure is recognised while the FSM has not yet reached FAIL,
  // since FAIL is entered exactly on the first failing sample and only
  // clear/reset leave it.
  always_comb begin
    mismatch_d      = mismatch_q;
    mismatch_ch_d   = mismatch_ch_q;
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    ch_err_cnt_d    = ch_err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_ch_d  = first_err_ch_q;
    if (clear) begin
      mismatch_d      = 1'b0;
      mismatch_ch_d   = '0;
      sample_cnt_d    = '0;
      err_cnt_d       = '0;
      ch_err_cnt_d    = '0;
      first_err_idx_d = '0;
      first_err_ch_d  = '0;
    end else if (sample) begin
      mismatch_d    = cmp_any;
      mismatch_ch_d = cmp_ch;
      sample_cnt_d  = sat_inc(sample_cnt_q);
      if (cmp_any) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
      for (int k = 0; k < NCH; k++) begin
        if (cmp_ch[k]) begin
          ch_err_cnt_d[k*CNT_W +: CNT_W] = sat_inc(ch_err_cnt_q[k*CNT_W +: CNT_W]);
        end
      end
      if (cmp_any && (state_q != ST_FAIL)) begin
        first_err_idx_d = sample_cnt_q;
        first_err_ch_d  = cmp_ch;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mismatch_q      <= 1'b0;
      mismatch_ch_q   <= '0;
      sample_cnt_q    <= '0;
      err_cnt_q       <= '0;
      ch_err_cnt_q    <= '0;
      first_err_idx_q <= '0;
      first_err_ch_q  <= '0;
    end else begin
      mismatch_q      <= mismatch_d;
      mismatch_ch_q   <= mismatch_ch_d;
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      ch_err_cnt_q    <= ch_err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_ch_q  <= first_err_ch_d;
    end
  end

  // Status FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Status FSM next-state: FAIL is sticky; only clear leaves it.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_EMPTY;
    end else if (sample) begin
      case (state_q)
        ST_EMPTY: state_d = cmp_any ? ST_FAIL : ST_PASS;
        ST_PASS:  state_d = cmp_any ? ST_FAIL : ST_PASS;
        ST_FAIL:  state_d = ST_FAIL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Status FSM outputs and register-to-port mapping.
  always_comb begin
    status        = state_q;
    mismatch      = mismatch_q;
    mismatch_ch   = mismatch_ch_q;
    sample_cnt    = sample_cnt_q;
    err_cnt       = err_cnt_q;
    ch_err_cnt    = ch_err_cnt_q;
    first_err_idx = first_err_idx_q;
    first_err_ch  = first_err_ch_q;
  end

endmodule
